// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered 8-entry descriptor table plus a 3-stage
// per-pixel hit/priority/ROM-address pipeline. Define SPRITE_HFLIP_EN to honour descriptor bit 26.
module sprite_compositor #(
  parameter int N_SPRITES  = 8,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int SHEET_COLS = 8,
  parameter int ROM_AW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [31:0]       dina,
  input  logic              frame_sync,
  input  logic              pix_valid,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic              out_valid,
  output logic              out_hit,
  output logic [2:0]        out_id,
  output logic              out_multi,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              frame_overlap
);

  localparam int DXW     = $clog2(SPR_W);
  localparam int DYW     = $clog2(SPR_H);
  localparam int SHEET_W = SHEET_COLS * SPR_W;

  logic [31:0] shadow [N_SPRITES];
  logic [31:0] active [N_SPRITES];

  // Writers only ever touch the shadow copy; a simultaneous write is folded into the frame copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (we)
        shadow[addr] <= dina;
      if (frame_sync) begin
        for (int i = 0; i < N_SPRITES; i++)
          active[i] <= shadow[i];
        if (we)
          active[addr] <= dina;
      end
    end
  end

  logic unused_desc;
  always_comb begin
    unused_desc = 1'b0;
    for (int i = 0; i < N_SPRITES; i++) begin
      unused_desc = unused_desc ^ (^active[i][30:27]);
`ifndef SPRITE_HFLIP_EN
      unused_desc = unused_desc ^ active[i][26];
`endif
    end
  end

  logic [N_SPRITES-1:0] hit_vec;
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_SPRITES; i++)
      hit_vec[i] = active[i][31] &&
                   ({1'b0, pix_x} >= {1'b0, active[i][25:16]}) &&
                   ({1'b0, pix_x} <  ({1'b0, active[i][25:16]} + 11'(SPR_W))) &&
                   ({1'b0, pix_y} >= {1'b0, active[i][15:6]}) &&
                   ({1'b0, pix_y} <  ({1'b0, active[i][15:6]} + 11'(SPR_H)));
  end

  // S1 snapshots per-entry offsets and attributes so a later table copy cannot leak into an in-flight query.
  logic                 s1_valid;
  logic [N_SPRITES-1:0] s1_hit;
  logic [DXW-1:0]       s1_dx  [N_SPRITES];
  logic [DYW-1:0]       s1_dy  [N_SPRITES];
  logic [2:0]           s1_row [N_SPRITES];
  logic [2:0]           s1_col [N_SPRITES];
`ifdef SPRITE_HFLIP_EN
  logic [N_SPRITES-1:0] s1_flip;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_dx[i]  <= '0;
        s1_dy[i]  <= '0;
        s1_row[i] <= '0;
        s1_col[i] <= '0;
      end
`ifdef SPRITE_HFLIP_EN
      s1_flip <= '0;
`endif
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= hit_vec;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_dx[i]  <= pix_x[DXW-1:0] - active[i][16 +: DXW];
        s1_dy[i]  <= pix_y[DYW-1:0] - active[i][6 +: DYW];
        s1_row[i] <= active[i][5:3];
        s1_col[i] <= active[i][2:0];
`ifdef SPRITE_HFLIP_EN
        s1_flip[i] <= active[i][26];
`endif
      end
    end
  end

  logic [2:0] win_id;
  logic       any_hit;
  logic       multi;
  always_comb begin
    int cnt;
    cnt     = 0;
    win_id  = '0;
    any_hit = 1'b0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_id  = 3'(i);
        any_hit = 1'b1;
        cnt++;
      end
    end
    multi = (cnt > 1);
  end

  logic           s2_valid;
  logic           s2_hit;
  logic [2:0]     s2_id;
  logic           s2_multi;
  logic [DXW-1:0] s2_dx;
  logic [DYW-1:0] s2_dy;
  logic [2:0]     s2_row;
  logic [2:0]     s2_col;
`ifdef SPRITE_HFLIP_EN
  logic           s2_flip;
`endif

  // Misses carry all-zero fields so S3 produces the zero miss result without extra muxing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_id    <= '0;
      s2_multi <= 1'b0;
      s2_dx    <= '0;
      s2_dy    <= '0;
      s2_row   <= '0;
      s2_col   <= '0;
`ifdef SPRITE_HFLIP_EN
      s2_flip  <= 1'b0;
`endif
    end else begin
      s2_valid <= s1_valid;
      s2_hit   <= any_hit;
      s2_id    <= win_id;
      s2_multi <= multi;
      s2_dx    <= any_hit ? s1_dx[win_id]  : '0;
      s2_dy    <= any_hit ? s1_dy[win_id]  : '0;
      s2_row   <= any_hit ? s1_row[win_id] : '0;
      s2_col   <= any_hit ? s1_col[win_id] : '0;
`ifdef SPRITE_HFLIP_EN
      s2_flip  <= any_hit && s1_flip[win_id];
`endif
    end
  end

  logic [DXW-1:0]    dx_eff;
  logic [ROM_AW-1:0] rom_next;
  always_comb begin
`ifdef SPRITE_HFLIP_EN
    dx_eff = s2_flip ? DXW'(SPR_W - 1) - s2_dx : s2_dx;
`else
    dx_eff = s2_dx;
`endif
    rom_next = ROM_AW'((32'(s2_row) * SPR_H + 32'(s2_dy)) * SHEET_W
                       + 32'(s2_col) * SPR_W + 32'(dx_eff));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_id    <= '0;
      out_multi <= 1'b0;
      rom_addr  <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_hit   <= s2_hit;
        out_id    <= s2_hit ? s2_id : 3'd0;
        out_multi <= s2_multi;
        rom_addr  <= s2_hit ? rom_next : '0;
      end
    end
  end

  // A multi result visible during the frame_sync cycle is charged to the frame that is starting.
  logic overlap_sticky;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overlap_sticky <= 1'b0;
      frame_overlap  <= 1'b0;
    end else if (frame_sync) begin
      frame_overlap  <= overlap_sticky;
      overlap_sticky <= out_valid && out_multi;
    end else if (out_valid && out_multi) begin
      overlap_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor; expected ROM addresses are hand-computed.
module tb_sprite_compositor;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] dina;
  logic        frame_sync;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        out_valid;
  logic        out_hit;
  logic [2:0]  out_id;
  logic        out_multi;
  logic [15:0] rom_addr;
  logic        frame_overlap;

  int checks = 0;
  int errors = 0;

  sprite_compositor dut (
    .clk           (clk),
    .reset         (reset),
    .we            (we),
    .addr          (addr),
    .dina          (dina),
    .frame_sync    (frame_sync),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .out_valid     (out_valid),
    .out_hit       (out_hit),
    .out_id        (out_id),
    .out_multi     (out_multi),
    .rom_addr      (rom_addr),
    .frame_overlap (frame_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic writeDesc(input logic [2:0] a, input logic [31:0] d, input logic sync);
    @(negedge clk);
    we = 1'b1; addr = a; dina = d; frame_sync = sync;
    @(negedge clk);
    we = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic pulseSync();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  // Drives one query and checks the result after the three pipeline registers, then the hold cycle.
  task automatic applyStimulus(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic hit, input logic [2:0] id, input logic multi,
                               input logic [15:0] rom);
    @(negedge clk);
    pix_valid = 1'b1; pix_x = x; pix_y = y;
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".hit"},   32'(out_hit),   32'(hit));
    checkOutput({tag, ".id"},    32'(out_id),    32'(id));
    checkOutput({tag, ".multi"}, 32'(out_multi), 32'(multi));
    checkOutput({tag, ".rom"},   32'(rom_addr),  32'(rom));
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".hold_hit"},   32'(out_hit),   32'(hit));
    checkOutput({tag, ".hold_rom"},   32'(rom_addr),  32'(rom));
  endtask

  initial begin
    logic [15:0] flip_rom;
    reset = 1'b0; we = 1'b0; addr = '0; dina = '0; frame_sync = 1'b0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    #12;
    checkOutput("rst.valid",   32'(out_valid),     32'd0);
    checkOutput("rst.hit",     32'(out_hit),       32'd0);
    checkOutput("rst.id",      32'(out_id),        32'd0);
    checkOutput("rst.multi",   32'(out_multi),     32'd0);
    checkOutput("rst.rom",     32'(rom_addr),      32'd0);
    checkOutput("rst.overlap", 32'(frame_overlap), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Sprite 0 at (80,400), sheet row 0 col 2: invisible until frame_sync.
    writeDesc(3'd0, 32'h8050_6402, 1'b0);
    applyStimulus("shadow_only", 10'd85, 10'd405, 1'b0, 3'd0, 1'b0, 16'd0);
    pulseSync();
    applyStimulus("basic",     10'd85,  10'd405, 1'b1, 3'd0, 1'b0, 16'd1349);
    applyStimulus("right_out", 10'd112, 10'd405, 1'b0, 3'd0, 1'b0, 16'd0);
    applyStimulus("left_out",  10'd79,  10'd405, 1'b0, 3'd0, 1'b0, 16'd0);
    applyStimulus("corner_br", 10'd111, 10'd431, 1'b1, 3'd0, 1'b0, 16'd8031);
    applyStimulus("corner_tl", 10'd80,  10'd400, 1'b1, 3'd0, 1'b0, 16'd64);
    applyStimulus("below_out", 10'd111, 10'd432, 1'b0, 3'd0, 1'b0, 16'd0);

    // Merged write+sync: sprite 2 at (1020,0), row 1 col 3, checked at the screen edge.
    writeDesc(3'd2, 32'h83FC_000B, 1'b1);
    applyStimulus("merged_edge", 10'd1023, 10'd31, 1'b1, 3'd2, 1'b0, 16'd16227);

    writeDesc(3'd0, 32'h8450_6402, 1'b1);
`ifdef SPRITE_HFLIP_EN
    flip_rom = 16'd1370;
`else
    flip_rom = 16'd1349;
`endif
    applyStimulus("hflip", 10'd85, 10'd405, 1'b1, 3'd0, 1'b0, flip_rom);

    // Sprites 1 and 3 both at (100,100): lowest index wins and overlap is flagged.
    writeDesc(3'd1, 32'h8064_1900, 1'b0);
    writeDesc(3'd3, 32'h8064_1900, 1'b0);
    pulseSync();
    checkOutput("overlap_before", 32'(frame_overlap), 32'd0);
    applyStimulus("multi", 10'd100, 10'd100, 1'b1, 3'd1, 1'b1, 16'd0);
    pulseSync();
    checkOutput("overlap_set", 32'(frame_overlap), 32'd1);
    pulseSync();
    checkOutput("overlap_clear", 32'(frame_overlap), 32'd0);

    // Continuous queries with reset asserted mid-burst.
    @(negedge clk);
    pix_valid = 1'b1; pix_x = 10'd85; pix_y = 10'd405;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("burst.valid", 32'(out_valid), 32'd1);
    checkOutput("burst.hit",   32'(out_hit),   32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst.valid", 32'(out_valid), 32'd0);
    checkOutput("midrst.hit",   32'(out_hit),   32'd0);
    checkOutput("midrst.rom",   32'(rom_addr),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    pix_valid = 1'b0;
    applyStimulus("after_rst", 10'd85, 10'd405, 1'b0, 3'd0, 1'b0, 16'd0);
    checkOutput("after_rst.overlap", 32'(frame_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Sits directly downstream of the player/enemy sprite controllers.
- Captures their 32-bit sprite descriptors (dina/addr write port) into an 8-entry attribute table.
- For each VGA pixel it returns whether a sprite covers that pixel, which sprite wins, and the sprite-sheet ROM address to fetch.
- Writes are double-buffered so that sprite moves land only on frame boundaries; this prevents tearing.

Parameters:
- N_SPRITES, 8, number of table entries; addr width is 3.
- SPR_W, 32, sprite width in pixels.
- SPR_H, 32, sprite height in pixels.
- SHEET_COLS, 8, frames per sheet row; the sheet is SHEET_COLS*SPR_W pixels wide.
- ROM_AW, 16, sprite-sheet ROM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  descriptor write strobe
- addr  in  3  table entry to write
- dina  in  32  descriptor: [31] enable, [30:27] reserved, [26] hflip, [25:16] x, [15:6] y, [5:3] sheet row, [2:0] sheet col
- frame_sync  in  1  one-cycle pulse at vertical blank start
- pix_valid  in  1  pixel query valid
- pix_x  in  10  query x
- pix_y  in  10  query y
- out_valid  out  1  result valid
- out_hit  out  1  some enabled sprite covers the pixel
- out_id  out  3  index of the winning sprite
- out_multi  out  1  two or more sprites cover the pixel
- rom_addr  out  ROM_AW  sheet address of the winning sprite texel
- frame_overlap  out  1  sticky flag: any out_multi seen during the previous frame

Behaviour:
- Reset (reset=0, asynchronous):
  - Shadow and active tables cleared, so all entries are disabled.
  - All pipeline valids are 0.
  - out_hit=0, out_id=0, out_multi=0, rom_addr=0, frame_overlap=0.
  - Pipeline contents are discarded when reset is asserted mid-query.
- Writes:
  - we=1 writes dina into shadow[addr] on the clk edge.
  - Reserved bits are stored but ignored.
  - The active table used for lookups is never written directly.
- frame_sync:
  - Copies all shadow entries into the active table in one cycle.
  - If we and frame_sync are asserted in the same cycle, the write is merged: active[addr] receives dina.
- Overlap flag:
  - An internal sticky bit sets whenever an out_multi=1 result is emitted.
  - On frame_sync, frame_overlap takes the sticky value and the sticky bit clears.
  - An out_multi result emitted in the same cycle as frame_sync counts toward the next frame.
- Hit test per entry i:
  - enable=1, and x_i <= pix_x < x_i+SPR_W, and y_i <= pix_y < y_i+SPR_H.
  - Sums are computed at 11 bits, so x=1020 covers 1020..1023 without wrapping.
- Pipeline: fixed 3-cycle latency, fully pipelined, accepts one query per cycle, no stall.
  - S1: register the N_SPRITES hit vector, pix_x, pix_y and the valid bit.
  - S2: priority-encode, lowest index wins; set multi = popcount>1; register dx=pix_x-x_win and dy=pix_y-y_win (5 bits each), plus row, col and hflip.
  - S3: rom_addr = (row*SPR_H+dy)*(SHEET_COLS*SPR_W) + col*SPR_W + dx', truncated to ROM_AW bits, where dx' is dx or the flipped value (see Optional Feature). out_valid = pix_valid delayed 3 cycles.
- On a miss: out_hit=0, out_id=0, out_multi=0, rom_addr=0.
- Outputs hold their last values while out_valid=0.
- A frame_sync mid-stream affects only queries that enter S1 after the copy cycle.

Optional Feature:
- Macro SPRITE_HFLIP_EN.
- Defined: dina[26] is honoured; when it is set, dx' = SPR_W-1-dx.
- Undefined: dina[26] is ignored, dx' = dx, and no flip logic is synthesised.

Test Plan:
- Write addr=0, dina=0x80506402 (x=80, y=400, row0, col2), then pulse frame_sync; query (85,405) -> 3 cycles later out_valid=1, out_hit=1, out_id=0, rom_addr=1349.
- Same sprite, query (112,405) and (79,405) -> out_hit=0, rom_addr=0. Query (111,431) -> hit, rom_addr=(31*256)+64+31=8031.
- Write without frame_sync, query (85,405) -> out_hit=0. Pulse frame_sync -> hit. Write and frame_sync in the same cycle -> the next query hits.
- Sprites 1 and 3 both at (100,100), query (100,100) -> out_id=1, out_multi=1. On the next frame_sync, frame_overlap=1; on the following frame_sync with no overlaps, frame_overlap=0.
- Continuous queries at 1/cycle with reset pulsed low mid-burst -> out_valid=0 immediately and the table is cleared. After release, a query at (85,405) returns out_hit=0.
- SPRITE_HFLIP_EN defined, dina=0x84506402, query (85,405) -> rom_addr=1280+64+26=1370. Undefined -> 1349.
